imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader_pack.sv | 50 +++++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader states and
// the word/byte geometry that the assembler and the loader both depend on.
package imem_loader_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_we;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   modport master (
      input  in_valid, in_data, in_last,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_data, in_last,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_loader_pack.sv
// Big-endian byte-to-word assembler: first byte lands in the top lane, and the
// first byte of every word clears the lower lanes so a short word is zero-filled.
module imem_loader_pack
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_flush,
   input  logic [BYTE_W-1:0] i_data,
   output logic [IDX_W-1:0]  o_idx,
   output logic [WORD_W-1:0] o_word
);

   logic [IDX_W-1:0] r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
      end else if (i_flush) begin
         r_idx <= '0;
      end else if (i_push) begin
         r_idx <= r_idx + IDX_W'(1);
      end
   end

   assign o_idx = r_idx;

   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         logic [BYTE_W-1:0] r_lane;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_lane <= '0;
            end else if (i_push) begin
               if (r_idx == IDX_W'(gi)) begin
                  r_lane <= i_data;
               end else if (r_idx == '0) begin
                  r_lane <= '0;
               end
            end
         end

         assign o_word[WORD_W-1-BYTE_W*gi -: BYTE_W] = r_lane;
      end
   endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into 32-bit instruction words and releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to treat the in_last byte as an XOR checksum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256,
   localparam int         WC_W      = $clog2(MAX_WORDS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   imem_loader_if.master   bus,
   output logic            cpu_run,
   output logic            load_done,
   output logic            load_err,
   output logic [WC_W-1:0] word_count
);

   state_t            r_state;
   state_t            w_state_next;
   logic [WC_W-1:0]   r_word_count;
   logic              r_last;
   logic              w_accept;
   logic              w_full;
   logic              w_push;
   logic              w_flush;
   logic              w_last_ok;
   logic [IDX_W-1:0]  w_idx;
   logic [WORD_W-1:0] w_word;

   assign w_accept = bus.in_valid && (r_state == ST_LOAD);
   assign w_full   = (r_word_count == WC_W'(MAX_WORDS));

   imem_loader_pack u_pack (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_flush (w_flush),
      .i_data  (bus.in_data),
      .o_idx   (w_idx),
      .o_word  (w_word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] r_csum;
   logic              r_csum_ok;

   // Verdict is latched with the checksum byte so a trailing partial word can still be written first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csum    <= '0;
         r_csum_ok <= 1'b0;
      end else begin
         if (w_push) begin
            r_csum <= r_csum ^ bus.in_data;
         end
         if (w_accept && bus.in_last) begin
            r_csum_ok <= (bus.in_data == r_csum);
         end
      end
   end

   assign w_last_ok = r_csum_ok;
`else
   assign w_last_ok = 1'b1;
`endif

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_flush      = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (w_accept) begin
               if (w_full) begin
                  w_state_next = ST_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
               end else if (bus.in_last) begin
                  if (w_idx != '0) begin
                     w_state_next = ST_WRITE;
                  end else if (bus.in_data == r_csum) begin
                     w_state_next = ST_DONE;
                  end else begin
                     w_state_next = ST_ERR;
                  end
`endif
               end else begin
                  w_push = 1'b1;
                  if (bus.in_last || (w_idx == IDX_W'(BYTES_PER_WORD - 1))) begin
                     w_state_next = ST_WRITE;
                  end
               end
            end
         end
         ST_WRITE: begin
            w_flush = 1'b1;
            if (r_last) begin
               w_state_next = w_last_ok ? ST_DONE : ST_ERR;
            end else begin
               w_state_next = ST_LOAD;
            end
         end
         default: w_state_next = r_state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_LOAD;
         r_word_count <= '0;
         r_last       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_last <= bus.in_last;
         end
         if (r_state == ST_WRITE) begin
            r_word_count <= r_word_count + WC_W'(1);
         end
      end
   end

   assign bus.in_ready  = (r_state == ST_LOAD);
   assign bus.mem_we    = (r_state == ST_WRITE);
   assign bus.mem_addr  = BASE_ADDR + (WORD_W'(r_word_count) << 2);
   assign bus.mem_wdata = w_word;
   assign cpu_run       = (r_state == ST_DONE);
   assign load_done     = (r_state == ST_DONE);
   assign load_err      = (r_state == ST_ERR);
   assign word_count    = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// images checked against a queue-based model of the load rules.
`timescale 1ns/1ps
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam int          MAXW = 2;
   localparam int          WCW  = $clog2(MAXW + 1);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cpu_run, load_done, load_err;
   logic [WCW-1:0] word_count;

   imem_loader_if bus();

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cpu_run    (cpu_run),
      .load_done  (load_done),
      .load_err   (load_err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] wq[$];
   logic [63:0] exp_wq[$];
   logic [7:0]  stim_q[$];
   int          exp_st, exp_nacc, exp_wc;
   int          cyc = 0, last_we_cyc = -1, run_cyc = -1;

   // Write monitor: records {addr, data} of each strobe and when the CPU is released.
   always @(negedge clk) begin
      cyc++;
      if (!rst && bus.mem_we) begin
         wq.push_back({bus.mem_addr, bus.mem_wdata});
         last_we_cyc = cyc;
      end
      if (!rst && cpu_run && run_cyc < 0) run_cyc = cyc;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      wq.delete();
      last_we_cyc = -1;
      run_cyc     = -1;
      rst = 1'b0;
   endtask

   // Offers the first n bytes of stim_q; in_last marks the final byte of stim_q.
   task automatic drive(input int n, input int max_gap, output int stalls, output bit tmo);
      stalls = 0;
      tmo    = 1'b0;
      for (int i = 0; i < n; i++) begin
         int g;
         int w;
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         bus.in_valid = 1'b0;
         repeat (g) @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = stim_q[i];
         bus.in_last  = (i == stim_q.size() - 1);
         w = 0;
         while (!bus.in_ready && w < 20) begin
            stalls++;
            w++;
            @(negedge clk);
         end
         if (!bus.in_ready) begin
            tmo = 1'b1;
            break;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Reference: bytes gather into words of four (short final word zero-padded),
   // any byte at capacity is an error, and with checksums the last byte is an XOR check.
   task automatic model();
      int         words;
      logic [7:0] x;
      logic [7:0] pend[$];
      logic [31:0] w;
      bit         last;
      words = 0;
      x = 8'h00;
      exp_wq.delete();
      exp_st = 0;
      exp_nacc = 0;
      foreach (stim_q[i]) begin
         last = (i == stim_q.size() - 1);
         exp_nacc++;
         if (words == MAXW) begin
            exp_st = 2;
            break;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (last) begin
            if (pend.size() > 0) begin
               w = 32'h0;
               for (int k = 0; k < pend.size(); k++) w[31-8*k -: 8] = pend[k];
               exp_wq.push_back({BASE + 32'(4 * words), w});
               words++;
            end
            exp_st = (stim_q[i] == x) ? 1 : 2;
            break;
         end
`endif
         pend.push_back(stim_q[i]);
         x ^= stim_q[i];
         if (pend.size() == 4 || last) begin
            w = 32'h0;
            for (int k = 0; k < pend.size(); k++) w[31-8*k -: 8] = pend[k];
            exp_wq.push_back({BASE + 32'(4 * words), w});
            words++;
            pend.delete();
         end
         if (last) exp_st = 1;
      end
      exp_wc = words;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
      checks++; if (bus.mem_addr !== BASE) begin errors++; $display("FAIL reset_mem_addr got %h want %h", bus.mem_addr, BASE); end
      checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
      checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset_cpu_run got %b want 0", cpu_run); end
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b want 0", load_done); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b want 0", load_err); end
      checks++; if (word_count !== WCW'(0)) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count); end
      $display("txn reset");
   endtask

   task automatic test_two_words();
      int st; bit tmo;
      stim_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h01, 8'h00, 8'h08};
      do_reset();
      drive(8, 0, st, tmo);
      repeat (3) @(negedge clk);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL two_words_timeout got %b want 0", tmo); end
      checks++; if (wq.size() != 2) begin errors++; $display("FAIL two_words_count got %0d want 2", wq.size()); end
      if (wq.size() == 2) begin
         checks++; if (wq[0] !== {BASE, 32'h8C010004}) begin errors++; $display("FAIL two_words_w0 got %h want %h", wq[0], {BASE, 32'h8C010004}); end
         checks++; if (wq[1] !== {BASE + 32'd4, 32'hAC010008}) begin errors++; $display("FAIL two_words_w1 got %h want %h", wq[1], {BASE + 32'd4, 32'hAC010008}); end
      end
      checks++; if (word_count !== WCW'(2)) begin errors++; $display("FAIL two_words_wc got %0d want 2", word_count); end
      checks++; if (run_cyc != last_we_cyc + 1) begin errors++; $display("FAIL two_words_run_delay got %0d want %0d", run_cyc, last_we_cyc + 1); end
      checks++; if (load_done !== 1'b1 || cpu_run !== 1'b1) begin errors++; $display("FAIL two_words_done got %b%b want 11", load_done, cpu_run); end
      $display("txn two_words writes %0d", wq.size());
   endtask

   task automatic test_partial();
      int st; bit tmo;
      stim_q = '{8'h20, 8'h08, 8'h00};
      do_reset();
      drive(3, 1, st, tmo);
      repeat (3) @(negedge clk);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL partial_timeout got %b want 0", tmo); end
      checks++; if (wq.size() != 1) begin errors++; $display("FAIL partial_count got %0d want 1", wq.size()); end
      if (wq.size() == 1) begin
         checks++; if (wq[0] !== {BASE, 32'h20080000}) begin errors++; $display("FAIL partial_w0 got %h want %h", wq[0], {BASE, 32'h20080000}); end
      end
      checks++; if (load_done !== 1'b1 || word_count !== WCW'(1)) begin errors++; $display("FAIL partial_done got %b/%0d want 1/1", load_done, word_count); end
      $display("txn partial writes %0d", wq.size());
   endtask

   task automatic test_overflow();
      int st; bit tmo;
      stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
      do_reset();
      drive(9, 0, st, tmo);
      repeat (4) @(negedge clk);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL overflow_timeout got %b want 0", tmo); end
      checks++; if (wq.size() != 2) begin errors++; $display("FAIL overflow_count got %0d want 2", wq.size()); end
      if (wq.size() == 2) begin
         checks++; if (wq[1] !== {BASE + 32'd4, 32'h05060708}) begin errors++; $display("FAIL overflow_w1 got %h want %h", wq[1], {BASE + 32'd4, 32'h05060708}); end
      end
      checks++; if (load_err !== 1'b1 || cpu_run !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL overflow_flags got err%b run%b done%b want err1 run0 done0", load_err, cpu_run, load_done); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL overflow_ready got %b want 0", bus.in_ready); end
      $display("txn overflow writes %0d", wq.size());
   endtask

   task automatic test_reset_abort();
      int st; bit tmo;
      stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_reset();
      drive(2, 0, st, tmo);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_mid_word got we%b rdy%b want we0 rdy1", bus.mem_we, bus.in_ready); end
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL abort_mid_word_writes got %0d want 0", wq.size()); end
      do_reset();
      drive(3, 0, st, tmo);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEF;
      bus.in_last  = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL abort_enter_write got %b want 1", bus.mem_we); end
      rst = 1'b1;
      #1;
      checks++; if (bus.mem_we !== 1'b0 || word_count !== WCW'(0)) begin errors++; $display("FAIL abort_mid_write got we%b wc%0d want we0 wc0", bus.mem_we, word_count); end
      stim_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h11};
      do_reset();
      drive(4, 0, st, tmo);
      repeat (2) @(negedge clk);
      checks++; if (wq.size() != 1) begin errors++; $display("FAIL abort_reload_count got %0d want 1", wq.size()); end
      if (wq.size() == 1) begin
         checks++; if (wq[0] !== {BASE, 32'hCAFEF00D}) begin errors++; $display("FAIL abort_reload_w0 got %h want %h", wq[0], {BASE, 32'hCAFEF00D}); end
      end
      checks++; if (word_count !== WCW'(1)) begin errors++; $display("FAIL abort_reload_wc got %0d want 1", word_count); end
      $display("txn reset_abort writes %0d", wq.size());
   endtask

   task automatic test_back_to_back();
      int st; bit tmo;
      stim_q.delete();
      for (int k = 0; k < 8; k++) stim_q.push_back(8'($urandom));
      do_reset();
      model();
      drive(8, 0, st, tmo);
      repeat (3) @(negedge clk);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL b2b_timeout got %b want 0", tmo); end
      checks++; if (st != 1) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 1", st); end
      checks++; if (wq.size() != exp_wq.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", wq.size(), exp_wq.size()); end
      for (int k = 0; k < wq.size() && k < exp_wq.size(); k++) begin
         checks++; if (wq[k] !== exp_wq[k]) begin errors++; $display("FAIL b2b_w%0d got %h want %h", k, wq[k], exp_wq[k]); end
      end
      $display("txn back_to_back writes %0d stalls %0d", wq.size(), st);
   endtask

   task automatic test_checksum();
      int st; bit tmo;
      for (int t = 0; t < 2; t++) begin
         stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
         stim_q.push_back((t == 0) ? 8'h08 : 8'h09);
         do_reset();
         drive(5, 1, st, tmo);
         repeat (3) @(negedge clk);
         checks++; if (wq.size() < 1 || wq[0] !== {BASE, 32'h12345678}) begin errors++; $display("FAIL csum%0d_w0 got %0d writes want %h first", t, wq.size(), {BASE, 32'h12345678}); end
`ifdef IMEM_LOADER_CHECKSUM_EN
         checks++; if (wq.size() != 1) begin errors++; $display("FAIL csum%0d_count got %0d want 1", t, wq.size()); end
         checks++; if (load_done !== 1'(t == 0) || load_err !== 1'(t == 1)) begin errors++; $display("FAIL csum%0d_flags got done%b err%b want done%b err%b", t, load_done, load_err, 1'(t == 0), 1'(t == 1)); end
`else
         checks++; if (wq.size() != 2 || wq[1] !== {BASE + 32'd4, (t == 0) ? 32'h08000000 : 32'h09000000}) begin errors++; $display("FAIL csum%0d_tail got %0d writes want 2 with zero-filled tail", t, wq.size()); end
         checks++; if (load_done !== 1'b1 || load_err !== 1'b0) begin errors++; $display("FAIL csum%0d_flags got done%b err%b want done1 err0", t, load_done, load_err); end
`endif
         $display("txn checksum %0d writes %0d", t, wq.size());
      end
   endtask

   task automatic test_random();
      int st; bit tmo; int len; logic [7:0] x;
      for (int n = 0; n < 40; n++) begin
         len = $urandom_range(10, 1);
         stim_q.delete();
         for (int k = 0; k < len; k++) stim_q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
         if ($urandom_range(1, 0) == 1) begin
            x = 8'h00;
            for (int k = 0; k < len - 1; k++) x ^= stim_q[k];
            stim_q[len-1] = x;
         end
`endif
         do_reset();
         model();
         drive(exp_nacc, 3, st, tmo);
         repeat (4) @(negedge clk);
         checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got %b want 0", n, tmo); end
         checks++; if (wq.size() != exp_wq.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", n, wq.size(), exp_wq.size()); end
         for (int k = 0; k < wq.size() && k < exp_wq.size(); k++) begin
            checks++; if (wq[k] !== exp_wq[k]) begin errors++; $display("FAIL rnd%0d_w%0d got %h want %h", n, k, wq[k], exp_wq[k]); end
         end
         checks++; if (word_count !== WCW'(exp_wc)) begin errors++; $display("FAIL rnd%0d_wc got %0d want %0d", n, word_count, exp_wc); end
         checks++; if (load_done !== 1'(exp_st == 1) || cpu_run !== 1'(exp_st == 1) || load_err !== 1'(exp_st == 2)) begin
            errors++; $display("FAIL rnd%0d_flags got done%b run%b err%b want state %0d", n, load_done, cpu_run, load_err, exp_st);
         end
         $display("txn random %0d len %0d writes %0d state %0d", n, len, wq.size(), exp_st);
      end
   endtask

   initial begin
      test_reset();
`ifndef IMEM_LOADER_CHECKSUM_EN
      test_two_words();
      test_partial();
`endif
      test_overflow();
      test_reset_abort();
      test_back_to_back();
      test_checksum();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
